debounce_sync: RTL

- Input conditioning stage for asynchronous level inputs such as buttons, switches and external strobes.
- Synchronises the raw input into the clk domain, then filters out bounces and glitches.
- Presents a clean, registered level to the downstream rising edge detector.
- Also reports filter activity and a saturating count of rejected glitches for debug.

---
 rtl/debounce_sync.sv | 100 ++++++++++
 1 files changed

// File: rtl/debounce_sync.sv
// Input conditioner: synchronises an asynchronous level, then only passes a new
// level once it has been seen for STABLE_CYCLES consecutive synchronized samples.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic        RESET_LEVEL   = 1'b0,
    parameter int unsigned GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_raw,
    output logic                o_level,
    output logic                o_busy,
    output logic [GLITCH_W-1:0] o_glitch_cnt
);

    localparam int unsigned          CNT_W      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [GLITCH_W-1:0]  GLITCH_MAX = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    // Synchronizer chain; only stage 0 ever looks at i_raw.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_raw};
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                level_q;
    logic                busy_q;
    logic [GLITCH_W-1:0] glitch_q;

    // A return of sync_s to level_q always aborts, even on the edge the count completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            level_q  <= RESET_LEVEL;
            busy_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (sync_s != level_q) begin
                        state_q <= ST_COUNT;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (sync_s == level_q) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        if (glitch_q != GLITCH_MAX) begin
                            glitch_q <= glitch_q + 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        level_q <= sync_s;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_level      = level_q;
    assign o_busy       = busy_q;
    assign o_glitch_cnt = glitch_q;

endmodule
